// File: rtl/bht_table_pkg.sv
// Shared definitions for the branch history table: counter encodings,
// default geometry and the saturating counter step.
package bht_table_pkg;

  localparam int unsigned DEF_N_ENTRY = 8;
  localparam int unsigned DEF_PC_W    = 32;
  localparam int unsigned CTR_W       = 2;

  localparam logic [CTR_W-1:0] STRONG_NT = 2'd0;
  localparam logic [CTR_W-1:0] WEAK_NT   = 2'd1;
  localparam logic [CTR_W-1:0] WEAK_T    = 2'd2;
  localparam logic [CTR_W-1:0] STRONG_T  = 2'd3;

  // Saturating step of a 2-bit direction counter toward taken (up) or not-taken.
  function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] ctr,
                                                input logic             up);
    logic [CTR_W-1:0] res;
    if (up) res = (ctr == STRONG_T)  ? STRONG_T  : ctr + 2'd1;
    else    res = (ctr == STRONG_NT) ? STRONG_NT : ctr - 2'd1;
    return res;
  endfunction

endpackage

// File: rtl/bht_table_lru.sv
// Shared recency tracker: true LRU over NItem slots kept as per-slot ages.
// Age 0 is most recent; the slot holding age NItem-1 is the victim.
module BhtLRU #(
  parameter int unsigned NItem = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             touch_en,
  input  logic [NItem-1:0] touch_item,
  output logic [NItem-1:0] lru_item
);

  localparam int unsigned IdxW = (NItem > 1) ? $clog2(NItem) : 1;

  logic [IdxW-1:0] age_q [NItem];
  logic [IdxW-1:0] age_d [NItem];
  logic [IdxW-1:0] touched_age;

  always_comb begin
    touched_age = '0;
    for (int i = 0; i < NItem; i++) begin
      if (touch_item[i]) touched_age = touched_age | age_q[i];
    end
  end

  // Touched slot becomes youngest; slots younger than it age by one.
  always_comb begin
    age_d = age_q;
    if (touch_en) begin
      for (int i = 0; i < NItem; i++) begin
        if (touch_item[i])                age_d[i] = '0;
        else if (age_q[i] < touched_age)  age_d[i] = age_q[i] + IdxW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NItem; i++) age_q[i] <= IdxW'(i);
    end else begin
      age_q <= age_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NItem; i++) lru_item[i] = (age_q[i] == IdxW'(NItem - 1));
  end

endmodule

// File: rtl/bht_table.sv
// Fully associative branch history table: combinational fetch-PC lookup,
// trained by resolved branches, victims chosen by the shared LRU tracker.
module bht_table
  import bht_table_pkg::*;
#(
  parameter int unsigned NEntry = DEF_N_ENTRY,
  parameter int unsigned PcW    = DEF_PC_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [PcW-1:0] lk_pc,
  output logic           lk_hit,
  output logic           lk_taken,
  output logic [PcW-1:0] lk_target,
  input  logic           upd_en,
  input  logic [PcW-1:0] upd_pc,
  input  logic           upd_taken,
  input  logic [PcW-1:0] upd_target,
  input  logic           flush
);

  localparam int unsigned TagW = PcW - 2;

  logic [NEntry-1:0] valid_q, valid_d;
  logic [TagW-1:0]   tag_q    [NEntry];
  logic [TagW-1:0]   tag_d    [NEntry];
  logic [PcW-1:0]    target_q [NEntry];
  logic [PcW-1:0]    target_d [NEntry];
  logic [CTR_W-1:0]  ctr_q    [NEntry];
  logic [CTR_W-1:0]  ctr_d    [NEntry];

  logic [NEntry-1:0] lk_match, umatch;
  logic [NEntry-1:0] first_inv, inv_seen, victim, lru_item;
  logic [NEntry-1:0] touch_item;
  logic              touch_en;
  logic              unused_pc_bits;

  assign unused_pc_bits = ^{lk_pc[1:0], upd_pc[1:0]};

  always_comb begin
    for (int i = 0; i < NEntry; i++) begin
      lk_match[i] = valid_q[i] && (tag_q[i] == lk_pc[PcW-1:2]);
      umatch[i]   = valid_q[i] && (tag_q[i] == upd_pc[PcW-1:2]);
    end
  end

  // At most one entry matches, so OR-reduction selects its fields.
  always_comb begin
    lk_hit    = 1'b0;
    lk_taken  = 1'b0;
    lk_target = '0;
    for (int i = 0; i < NEntry; i++) begin
      if (lk_match[i]) begin
        lk_hit    = 1'b1;
        lk_taken  = lk_taken | ctr_q[i][1];
        lk_target = lk_target | target_q[i];
      end
    end
  end

  for (genvar g = 0; g < NEntry; g++) begin : g_first_inv
    if (g == 0) begin : g_lsb
      assign first_inv[g] = ~valid_q[g];
      assign inv_seen[g]  = ~valid_q[g];
    end else begin : g_rest
      assign first_inv[g] = ~valid_q[g] & ~inv_seen[g-1];
      assign inv_seen[g]  = ~valid_q[g] | inv_seen[g-1];
    end
  end

  assign victim = inv_seen[NEntry-1] ? first_inv : lru_item;

  // Training: hit adjusts counter/target, taken miss allocates the victim.
  always_comb begin
    valid_d    = valid_q;
    tag_d      = tag_q;
    target_d   = target_q;
    ctr_d      = ctr_q;
    touch_en   = 1'b0;
    touch_item = '0;
    if (flush) begin
      valid_d = '0;
    end else if (upd_en) begin
      if (|umatch) begin
        touch_en   = 1'b1;
        touch_item = umatch;
        for (int i = 0; i < NEntry; i++) begin
          if (umatch[i]) begin
            ctr_d[i] = ctr_step(ctr_q[i], upd_taken);
            if (upd_taken) target_d[i] = upd_target;
          end
        end
      end else if (upd_taken) begin
        touch_en   = 1'b1;
        touch_item = victim;
        for (int i = 0; i < NEntry; i++) begin
          if (victim[i]) begin
            valid_d[i]  = 1'b1;
            tag_d[i]    = upd_pc[PcW-1:2];
            target_d[i] = upd_target;
            ctr_d[i]    = WEAK_T;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < NEntry; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= STRONG_NT;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

  BhtLRU #(
    .NItem(NEntry)
  ) u_lru (
    .clk       (clk),
    .rst_n     (rst_n),
    .touch_en  (touch_en),
    .touch_item(touch_item),
    .lru_item  (lru_item)
  );

endmodule

// File: tb/tb_bht_table.sv
// Directed bench for bht_table: expected lookup results are queued when the
// stimulus is driven and popped when the outputs are sampled.
module tb_bht_table;

  localparam int unsigned NEntry = 8;
  localparam int unsigned PcW    = 32;

  logic           clk;
  logic           rst_n;
  logic [PcW-1:0] lk_pc;
  logic           lk_hit;
  logic           lk_taken;
  logic [PcW-1:0] lk_target;
  logic           upd_en;
  logic [PcW-1:0] upd_pc;
  logic           upd_taken;
  logic [PcW-1:0] upd_target;
  logic           flush;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  bht_table #(.NEntry(NEntry), .PcW(PcW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lk_pc     (lk_pc),
    .lk_hit    (lk_hit),
    .lk_taken  (lk_taken),
    .lk_target (lk_target),
    .upd_en    (upd_en),
    .upd_pc    (upd_pc),
    .upd_taken (upd_taken),
    .upd_target(upd_target),
    .flush     (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb.push_back('{tag: tag, exp: exp});
  endtask

  task automatic sb_pop_check(input logic [31:0] obs);
    sb_item_t e;
    if (sb.size() == 0) begin
      check_val("scoreboard_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_val(e.tag, obs, e.exp);
    end
  endtask

  // Present pc on the lookup port and check all three outputs, mid-cycle.
  task automatic lookup_now(input string tag, input logic [31:0] pc,
                            input bit hit, input bit tk, input logic [31:0] tgt);
    lk_pc = pc;
    sb_push({tag, "_hit"},    32'(hit));
    sb_push({tag, "_taken"},  32'(tk));
    sb_push({tag, "_target"}, tgt);
    #1;
    sb_pop_check(32'(lk_hit));
    sb_pop_check(32'(lk_taken));
    sb_pop_check(lk_target);
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc,
                        input bit hit, input bit tk, input logic [31:0] tgt);
    @(negedge clk);
    lookup_now(tag, pc, hit, tk, tgt);
  endtask

  task automatic upd(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
    @(negedge clk);
    upd_en     = 1'b1;
    upd_pc     = pc;
    upd_taken  = tk;
    upd_target = tgt;
  endtask

  task automatic idle();
    @(negedge clk);
    upd_en = 1'b0;
    flush  = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    lk_pc      = 32'h100;
    upd_en     = 1'b0;
    upd_pc     = '0;
    upd_taken  = 1'b0;
    upd_target = '0;
    flush      = 1'b0;
    #2;
    lookup_now("reset_in", 32'h100, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    lookup("reset_out", 32'h100, 1'b0, 1'b0, 32'h0);

    // Allocate 0x100 and walk its counter down and back up.
    upd(32'h100, 1'b1, 32'h200);
    idle();
    lookup_now("alloc", 32'h100, 1'b1, 1'b1, 32'h200);
    upd(32'h100, 1'b0, 32'hDEAD);
    upd(32'h100, 1'b0, 32'hBEEF);
    idle();
    lookup_now("two_nt", 32'h100, 1'b1, 1'b0, 32'h200);
    upd(32'h100, 1'b0, 32'h0);
    upd(32'h100, 1'b1, 32'h204);
    idle();
    lookup_now("sat_low_then_t", 32'h100, 1'b1, 1'b0, 32'h204);
    upd(32'h100, 1'b1, 32'h208);
    idle();
    lookup_now("retrain_t", 32'h100, 1'b1, 1'b1, 32'h208);

    // Not-taken miss must neither allocate nor touch.
    upd(32'h300, 1'b0, 32'h600);
    sb_push("nt_miss_touch", 32'd0);
    #1;
    sb_pop_check(32'(dut.touch_en));
    idle();
    lookup_now("nt_miss", 32'h300, 1'b0, 1'b0, 32'h0);

    // Same-cycle lookup of an updating PC sees the old state.
    upd(32'h400, 1'b1, 32'h800);
    lookup_now("same_cycle", 32'h400, 1'b0, 1'b0, 32'h0);
    idle();
    lookup_now("same_next", 32'h400, 1'b1, 1'b1, 32'h800);

    // Flush drops the concurrent update and clears everything.
    upd(32'h500, 1'b1, 32'hA00);
    flush = 1'b1;
    sb_push("flush_touch", 32'd0);
    #1;
    sb_pop_check(32'(dut.touch_en));
    idle();
    lookup_now("flush_100", 32'h100, 1'b0, 1'b0, 32'h0);
    lookup("flush_400", 32'h400, 1'b0, 1'b0, 32'h0);
    lookup("flush_500", 32'h500, 1'b0, 1'b0, 32'h0);

    // Fill all entries, refresh the first, then force an LRU eviction.
    for (int k = 0; k < 8; k++) upd(32'h1000 + 32'(4 * k), 1'b1, 32'h3000 + 32'(k));
    upd(32'h1000, 1'b1, 32'h3100);
    upd(32'h2000, 1'b1, 32'h4000);
    idle();
    lookup_now("evict_1004", 32'h1004, 1'b0, 1'b0, 32'h0);
    lookup("keep_1000", 32'h1000, 1'b1, 1'b1, 32'h3100);
    lookup("new_2000", 32'h2000, 1'b1, 1'b1, 32'h4000);
    lookup("keep_1008", 32'h1008, 1'b1, 1'b1, 32'h3002);
    lookup("keep_101c", 32'h101C, 1'b1, 1'b1, 32'h3007);

    // Asynchronous reset mid-cycle, with an update in flight.
    upd(32'h1010, 1'b0, 32'h0);
    lookup_now("pre_rst", 32'h2000, 1'b1, 1'b1, 32'h4000);
    #1;
    rst_n = 1'b0;
    lookup_now("async_rst", 32'h2000, 1'b0, 1'b0, 32'h0);
    idle();
    rst_n = 1'b1;
    lookup("post_rst", 32'h1000, 1'b0, 1'b0, 32'h0);

    if (sb.size() != 0) check_val("scoreboard_leftover", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
